// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op-mode encoding
// and the chunk-width helpers used to split the carry chain across stages.
package adder_pkg;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } op_mode_t;

   // Width of every chunk except the last one.
   function automatic int chunk_w(input int width, input int stages);
      return (width + stages - 1) / stages;
   endfunction

   // Width of the last (most significant) chunk.
   function automatic int last_w(input int width, input int stages);
      return width - (stages - 1) * chunk_w(width, stages);
   endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline slice of adder_pipe_n: adds one CW-bit chunk at offset LO
// using the carry registered by the previous slice, and carries the full
// operands plus the partially built sum forward in its register slice.
module adder_pipe_stage #(
   parameter int WIDTH = 32,
   parameter int LO    = 0,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_x,
   input  logic [WIDTH-1:0] up_y,
   input  logic [WIDTH-1:0] up_sum,
   input  logic             up_carry,
   input  logic             dn_ready,
   output logic             valid,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic             adv;
   logic [CW:0]      chunk;
   logic [WIDTH-1:0] sum_nxt;

   // The slice moves when it is empty or when the slice after it moves.
   assign adv      = ~valid | dn_ready;
   assign up_ready = adv;

   // Chunk adder: fill in this slice's bits of the running sum.
   always_comb begin
      chunk = {1'b0, up_x[LO +: CW]} + {1'b0, up_y[LO +: CW]} + {{CW{1'b0}}, up_carry};
      sum_nxt = up_sum;
      sum_nxt[LO +: CW] = chunk[CW-1:0];
   end

   // Register slice: data only loads with a valid op so an emptied slice
   // keeps the last value that passed through it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         x     <= '0;
         y     <= '0;
         sum   <= '0;
         carry <= 1'b0;
      end else if (adv) begin
         valid <= up_valid;
         if (up_valid) begin
            x     <= up_x;
            y     <= up_y;
            sum   <= sum_nxt;
            carry <= chunk[CW];
         end
      end
   end

endmodule

// File: rtl/adder_pipe_n.sv
// Pipelined signed/unsigned add/subtract unit with valid/ready handshake.
// The carry chain is split into STAGES registered chunks; latency is STAGES
// cycles and throughput one op per cycle. The last slice's registers are the
// output registers.
// Optional feature: define ADDER_SAT_EN to saturate the sum on signed
// overflow (carry and overflow still describe the raw result).
module adder_pipe_n
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int CHUNK = chunk_w(WIDTH, STAGES);
   localparam int LAST  = last_w(WIDTH, STAGES);

   op_mode_t         mode;
   logic [STAGES:0]  vld;
   logic [STAGES:0]  rdy;
   logic [STAGES:0]  cs;
   logic [WIDTH-1:0] xs [STAGES+1];
   logic [WIDTH-1:0] ys [STAGES+1];
   logic [WIDTH-1:0] ss [STAGES+1];
   logic [WIDTH-1:0] raw;
   logic             x_msb;
   logic             y_msb;

   // Subtraction is X + ~Y + ~cin, so the borrow-in inverts as well.
   assign mode   = op_mode_t'(sub);
   assign vld[0] = in_valid;
   assign xs[0]  = X;
   assign ys[0]  = (mode == SUB) ? ~Y : Y;
   assign cs[0]  = (mode == SUB) ? ~cin : cin;
   assign ss[0]  = '0;

   // Ready ripples combinationally back from the sink, so a full pipe with
   // out_ready high still accepts a new op every cycle.
   assign rdy[STAGES] = out_ready;
   assign in_ready    = rdy[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int CWK = (k == STAGES - 1) ? LAST : CHUNK;
      adder_pipe_stage #(
         .WIDTH (WIDTH),
         .LO    (k * CHUNK),
         .CW    (CWK)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_valid (vld[k]),
         .up_ready (rdy[k]),
         .up_x     (xs[k]),
         .up_y     (ys[k]),
         .up_sum   (ss[k]),
         .up_carry (cs[k]),
         .dn_ready (rdy[k+1]),
         .valid    (vld[k+1]),
         .x        (xs[k+1]),
         .y        (ys[k+1]),
         .sum      (ss[k+1]),
         .carry    (cs[k+1])
      );
   end

   // Overflow: operands of equal sign produced a wrapped sum of the other sign.
   assign raw       = ss[STAGES];
   assign x_msb     = xs[STAGES][WIDTH-1];
   assign y_msb     = ys[STAGES][WIDTH-1];
   assign out_valid = vld[STAGES];
   assign carry     = cs[STAGES];
   assign overflow  = (x_msb == y_msb) & (raw[WIDTH-1] != x_msb);

`ifdef ADDER_SAT_EN
   // Clamp toward the sign of the operands when the raw result overflowed.
   always_comb begin
      sum = raw;
      if (overflow) begin
         sum = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign sum = raw;
`endif

endmodule

// File: tb/tb_adder_pipe_n.sv
// Self-checking bench for adder_pipe_n: directed ops with literal results,
// a streamed sequence, backpressure, mid-flight reset, and sweeps of the
// WIDTH=7/STAGES=3 and STAGES=1 configurations against an arithmetic model.
module tb_adder_pipe_n;

   logic clk;
   logic rst_n;

   logic       iv0, sub0, cin0, ordy0;
   logic [7:0] x0, y0;
   logic       ir0, ov0, c0o, of0;
   logic [7:0] s0;

   logic       ivs, subs, cins, ordys;
   logic [7:0] xs, ys;
   logic       ir7, ov7, c7, of7;
   logic [6:0] s7;
   logic       ir1, ov1, c1, of1;
   logic [7:0] s1;

   int checks;
   int errors;

   logic [9:0] q0[$];
   logic [9:0] q1[$];
   logic [9:0] q2[$];
   logic       prev_stall;
   logic [9:0] prev_out;

`ifdef ADDER_SAT_EN
   localparam logic [7:0] E1_SUM  = 8'h7F;
   localparam logic [7:0] E2B_SUM = 8'h80;
   localparam logic [6:0] E7_SUM  = 7'h3F;
`else
   localparam logic [7:0] E1_SUM  = 8'h80;
   localparam logic [7:0] E2B_SUM = 8'h7F;
   localparam logic [6:0] E7_SUM  = 7'h40;
`endif

   adder_pipe_n #(.WIDTH(8), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .sub(sub0), .cin(cin0),
      .X(x0), .Y(y0), .out_valid(ov0), .out_ready(ordy0), .sum(s0), .carry(c0o), .overflow(of0)
   );

   adder_pipe_n #(.WIDTH(7), .STAGES(3)) dut7 (
      .clk(clk), .rst_n(rst_n), .in_valid(ivs), .in_ready(ir7), .sub(subs), .cin(cins),
      .X(xs[6:0]), .Y(ys[6:0]), .out_valid(ov7), .out_ready(ordys), .sum(s7), .carry(c7), .overflow(of7)
   );

   adder_pipe_n #(.WIDTH(8), .STAGES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(ivs), .in_ready(ir1), .sub(subs), .cin(cins),
      .X(xs), .Y(ys), .out_valid(ov1), .out_ready(ordys), .sum(s1), .carry(c1), .overflow(of1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {overflow, carry, sum} from true unsigned and signed arithmetic.
   function automatic logic [9:0] model(input int w, input int x, input int y, input bit sb, input bit ci);
      int m, hi, lo, sx, sy, u, t;
      logic [7:0] s;
      bit c, o;
      m  = 1 << w;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      sx = (x > hi) ? x - m : x;
      sy = (y > hi) ? y - m : y;
      if (sb) begin
         u = x - y - int'(ci);
         c = (u >= 0);
         t = sx - sy - int'(ci);
      end else begin
         u = x + y + int'(ci);
         c = (u >= m);
         t = sx + sy + int'(ci);
      end
      o = (t > hi) || (t < lo);
      s = 8'(u & (m - 1));
`ifdef ADDER_SAT_EN
      if (o) s = (t > hi) ? 8'(hi) : 8'(lo & (m - 1));
`endif
      return {o, c, s};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   // Scoreboard step for one DUT: compare a departing result, then record an arriving op.
   task automatic mon(input int id, input int w, input logic iv, input logic ir, input logic ov,
                      input logic ordy, input logic [7:0] xx, input logic [7:0] yy, input logic sb,
                      input logic ci, input logic [7:0] s, input logic c, input logic o);
      logic [9:0] e;
      int n;
      if (ov && ordy) begin
         n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
         if (n == 0) begin
            chk($sformatf("unexpected_out_dut%0d", id), 32'({o, c, s}), 32'h400);
         end else begin
            case (id)
               0:       e = q0.pop_front();
               1:       e = q1.pop_front();
               default: e = q2.pop_front();
            endcase
            chk($sformatf("result_dut%0d", id), 32'({o, c, s}), 32'(e));
         end
      end
      if (iv && ir) begin
         e = model(w, int'(xx), int'(yy), sb, ci);
         case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         q2.delete();
         prev_stall <= 1'b0;
      end else begin
         mon(0, 8, iv0, ir0, ov0, ordy0, x0, y0, sub0, cin0, s0, c0o, of0);
         mon(1, 7, ivs, ir7, ov7, ordys, {1'b0, xs[6:0]}, {1'b0, ys[6:0]}, subs, cins, {1'b0, s7}, c7, of7);
         mon(2, 8, ivs, ir1, ov1, ordys, xs, ys, subs, cins, s1, c1, of1);
         if (prev_stall && ov0) chk("stall_hold", 32'({of0, c0o, s0}), 32'(prev_out));
         prev_stall <= ov0 && !ordy0;
         prev_out   <= {of0, c0o, s0};
      end
   end

   // One op on the main DUT, checking latency and a literal result.
   task automatic one_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic sb, input logic ci, input logic [9:0] exp);
      x0 = a; y0 = b; sub0 = sb; cin0 = ci; iv0 = 1'b1;
      @(posedge clk); #1 iv0 = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk({nm, "_early"}, 32'(ov0), 32'd0);
      @(posedge clk);
      #1 chk({nm, "_valid"}, 32'(ov0), 32'd1);
      chk({nm, "_res"}, 32'({of0, c0o, s0}), 32'(exp));
   endtask

   // Hold an op until the handshake completes, bounded.
   task automatic send_hs(input logic [7:0] a, input logic [7:0] b, input logic sb, input logic ci);
      bit ok;
      x0 = a; y0 = b; sub0 = sb; cin0 = ci; iv0 = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         #1 ok = ir0;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 40 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(posedge clk);
      #1 chk(nm, 32'(q0.size() + q1.size() + q2.size()), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: actual running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0;
      iv0 = 0; sub0 = 0; cin0 = 0; x0 = 0; y0 = 0; ordy0 = 1;
      ivs = 0; subs = 0; cins = 0; xs = 0; ys = 0; ordys = 1;

      chk("model_add_ovf",  32'(model(8, 'h7F, 'h01, 1'b0, 1'b0)), 32'({2'b10, E1_SUM}));
      chk("model_sub_brw",  32'(model(8, 'h00, 'h01, 1'b1, 1'b0)), 32'({2'b00, 8'hFF}));
      chk("model_sub_ovf",  32'(model(8, 'h80, 'h01, 1'b1, 1'b0)), 32'({2'b11, E2B_SUM}));
      chk("model_add_cin",  32'(model(8, 'hFF, 'h01, 1'b0, 1'b1)), 32'({2'b01, 8'h01}));
      chk("model_sub_cin",  32'(model(8, 'h05, 'h03, 1'b1, 1'b1)), 32'({2'b01, 8'h01}));
      chk("model_w7_ovf",   32'(model(7, 'h3F, 'h01, 1'b0, 1'b0)), 32'({2'b10, 1'b0, E7_SUM}));

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(ov0), 32'd0);
      chk("rst_sum",       32'(s0), 32'd0);
      chk("rst_carry",     32'(c0o), 32'd0);
      chk("rst_overflow",  32'(of0), 32'd0);
      chk("rst_out_valid7", 32'(ov7), 32'd0);
      chk("rst_out_valid1", 32'(ov1), 32'd0);
      rst_n = 1'b1;
      #1 chk("rst_in_ready", 32'(ir0), 32'd1);
      @(posedge clk); #1;

      one_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, {2'b10, E1_SUM});
      one_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b0, {2'b00, 8'hFF});
      one_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, {2'b11, E2B_SUM});
      one_op("add_ff_01c", 8'hFF, 8'h01, 1'b0, 1'b1, {2'b01, 8'h01});

      for (int i = 0; i < 20; i++) begin
         if (i < 16) begin
            iv0 = 1'b1; x0 = 8'($urandom); y0 = 8'($urandom);
            sub0 = 1'($urandom_range(0, 1)); cin0 = 1'($urandom_range(0, 1));
         end else begin
            iv0 = 1'b0;
         end
         @(posedge clk);
         #1 chk($sformatf("stream_valid_%0d", i), 32'(ov0), 32'((i >= 3 && i <= 18) ? 1 : 0));
      end
      wait_drain("stream_drain");
      @(posedge clk); #1;

      fork
         begin
            for (int i = 0; i < 12; i++)
               send_hs(8'(i * 37 + 5), 8'(i * 91 + 3), 1'(i % 3 == 0), 1'(i % 2));
            iv0 = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1 ordy0 = 1'b0;
            repeat (6) @(posedge clk);
            #1 chk("bp_in_ready_low", 32'(ir0), 32'd0);
            chk("bp_out_held", 32'(ov0), 32'd1);
            ordy0 = 1'b1;
         end
      join
      wait_drain("bp_drain");
      @(posedge clk); #1;

      one_op("pre_rst", 8'h12, 8'h34, 1'b0, 1'b0, {2'b00, 8'h46});
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         iv0 = 1'b1; x0 = 8'(i + 1); y0 = 8'(i + 2); sub0 = 1'b0; cin0 = 1'b0;
         @(posedge clk); #1;
      end
      iv0 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(ov0), 32'd0);
      chk("midrst_sum",       32'(s0), 32'd0);
      @(negedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 chk($sformatf("no_stale_%0d", i), 32'(ov0), 32'd0);
      end

      for (int i = 0; i < 65536; i++) begin
         ivs = 1'b1;
         xs = 8'(i >> 8); ys = 8'(i);
         subs = xs[7]; cins = ys[7];
         @(posedge clk); #1;
      end
      ivs = 1'b0;
      wait_drain("sweep_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
